// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-port memory arbiter: FSM state encoding and owner codes.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    localparam logic OWN_FETCH = 1'b0;
    localparam logic OWN_DATA  = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin pick: a lone requester always wins, a tie goes to the one not served last.
module rr_pick2
    import arb_pkg::*;
(
    input  logic req_f,
    input  logic req_d,
    input  logic last,
    output logic win
);

    always_comb begin
        if (req_f && req_d) begin
            win = ~last;
        end else if (req_d) begin
            win = OWN_DATA;
        end else begin
            win = OWN_FETCH;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data memory arbiter with round-robin grant and a single outstanding access.
// Optional BUSY timeout abort is built when ARB_TIMEOUT_EN is defined.
//
// state | meaning
// IDLE  | no access in flight; arbitrate and latch the winner's payload
// BUSY  | mem_req asserted from the latched payload, waiting on mem_ready
// DONE  | one-cycle ack (and err on abort) to the owner, update last-served
module mem_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_ack,
    output logic [DATA_W-1:0] f_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              err,
    output logic              owner
);

    arb_state_t        state_q, state_d;
    logic              last_q, grant_q, win, owner_i, to_fire;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;

    rr_pick2 u_pick (
        .req_f (f_req),
        .req_d (d_req),
        .last  (last_q),
        .win   (win)
    );

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q;
    logic             to_q;

    // Abort on the BUSY cycle whose increment would reach TIMEOUT.
    assign to_fire = (state_q == BUSY) && !mem_ready && (cnt_q == CNT_W'(TIMEOUT - 1));
    assign err     = (state_q == DONE) && to_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            to_q  <= 1'b0;
        end else begin
            if (state_q != BUSY) begin
                cnt_q <= '0;
            end else if (!mem_ready) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (state_q == BUSY) begin
                to_q <= to_fire;
            end
        end
    end
`else
    assign to_fire = 1'b0;
    assign err     = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mem_req = 1'b0;
        mem_we  = 1'b0;
        f_ack   = 1'b0;
        d_ack   = 1'b0;
        owner_i = last_q;
        case (state_q)
            IDLE: begin
                if (f_req || d_req) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                mem_req = 1'b1;
                mem_we  = we_q;
                owner_i = grant_q;
                if (mem_ready || to_fire) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                owner_i = grant_q;
                f_ack   = (grant_q == OWN_FETCH);
                d_ack   = (grant_q == OWN_DATA);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // last_q resets to data, so owner is masked while reset is held.
    assign owner     = owner_i & rst;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q  <= OWN_DATA;
            grant_q <= OWN_FETCH;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            f_rdata <= '0;
            d_rdata <= '0;
        end else begin
            if (state_q == IDLE && (f_req || d_req)) begin
                grant_q <= win;
                if (win == OWN_DATA) begin
                    addr_q  <= d_addr;
                    we_q    <= d_we;
                    wdata_q <= d_wdata;
                end else begin
                    addr_q  <= f_addr;
                    we_q    <= 1'b0;
                    wdata_q <= '0;
                end
            end
            if (state_q == BUSY && mem_ready) begin
                if (grant_q == OWN_FETCH) begin
                    f_rdata <= mem_rdata;
                end else begin
                    d_rdata <= mem_rdata;
                end
            end
            if (state_q == DONE) begin
                last_q <= grant_q;
            end
        end
    end

endmodule
